// File: rtl/asic_cfg_pkg.sv
// Shared opcodes, status bit positions and FSM state encoding for the config sequencer.
package asic_cfg_pkg;

  localparam logic [7:0] OP_LOAD_STAT = 8'hA5;
  localparam logic [7:0] OP_LOAD_DYN  = 8'h5A;
  localparam logic [7:0] OP_RUN_ALL   = 8'hC3;
  localparam logic [7:0] OP_RUN_DYN   = 8'h3C;

  localparam int unsigned ST_DONE     = 0;
  localparam int unsigned ST_STAT_MIS = 1;
  localparam int unsigned ST_DYN_MIS  = 2;
  localparam int unsigned ST_STAT_TO  = 3;
  localparam int unsigned ST_DYN_TO   = 4;
  localparam int unsigned ST_BAD_CMD  = 7;

  localparam logic [7:0] STATUS_DONE = 8'(1 << ST_DONE);

  localparam int unsigned STAT_BYTES = 11;
  localparam int unsigned DYN_BYTES  = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_STAT,
    S_LOAD_DYN,
    S_ARM,
    S_RUN_STAT,
    S_WAIT_STAT_LOW,
    S_GAP,
    S_RUN_DYN,
    S_WAIT_DYN_LOW,
    S_REPORT
  } state_t;

endpackage

// File: rtl/asic_cfg_timer.sv
// Loadable down-counter; expires when the count reaches zero and then holds.
module asic_cfg_timer #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired_c
);

  logic [W-1:0] r_count;

  // Count register: load wins, otherwise count down to zero and stop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/asic_cfg_sequencer.sv
// Host-command front end for the ASIC bridge: loads config words, sequences
// the static/dynamic configuration handshakes and returns one status byte per command.
module asic_cfg_sequencer
  import asic_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned SIZESRSTAT     = STAT_BYTES * 8,
  parameter int unsigned SIZESRDYN      = DYN_BYTES * 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [SIZESRSTAT-1:0] static_conf_ear,
  output logic [SIZESRDYN-1:0]  dynamic_conf,
  output logic                  start_ASIC_config,
  output logic                  flag_stat,
  output logic                  flag_dyn,
  input  logic                  end_config,
  input  logic                  xor_out_stat,
  input  logic                  xor_out_dyn,
  output logic                  busy
);

  localparam int unsigned STAT_B  = SIZESRSTAT / 8;
  localparam int unsigned DYN_B   = SIZESRDYN / 8;
  localparam int unsigned MAX_B   = (STAT_B > DYN_B) ? STAT_B : DYN_B;
  localparam int unsigned CW      = $clog2(MAX_B + 1);
  localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  // Intervals are loaded as N-1 so the transition lands exactly N edges after the load edge.
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t r_state, w_state_nxt;

  logic [SIZESRSTAT-1:0] r_shadow_stat, w_stat_word;
  logic [SIZESRDYN-1:0]  r_shadow_dyn, w_dyn_word;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [7:0]            r_status, w_status_nxt;
  logic                  r_run_all, w_run_all_nxt;

  logic                  w_shift_stat, w_shift_dyn, w_commit_stat, w_commit_dyn;
  logic                  w_tmr_load, w_tmr_expired;
  logic [TW-1:0]         w_tmr_value;
  logic                  w_rx_fire, w_tx_fire;

  logic                  r_rx_ready, r_tx_valid, r_start, r_flag_stat, r_flag_dyn, r_busy;
  logic [7:0]            r_tx_data;
  logic [SIZESRSTAT-1:0] r_static_conf;
  logic [SIZESRDYN-1:0]  r_dyn_conf;

  logic                  w_rx_ready_nxt, w_tx_valid_nxt, w_start_nxt;
  logic                  w_flag_stat_nxt, w_flag_dyn_nxt, w_busy_nxt;
  logic [7:0]            w_tx_data_nxt;

  assign w_rx_fire   = rx_valid & r_rx_ready;
  assign w_tx_fire   = r_tx_valid & tx_ready;
  assign w_stat_word = SIZESRSTAT'({r_shadow_stat, rx_data});
  assign w_dyn_word  = SIZESRDYN'({r_shadow_dyn, rx_data});

  asic_cfg_timer #(
    .W (TW)
  ) u_timer (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_load      (w_tmr_load),
    .i_value     (w_tmr_value),
    .o_expired_c (w_tmr_expired)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, status accumulation and timer/load control.
  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_cnt_nxt     = r_cnt;
    w_run_all_nxt = r_run_all;
    w_tmr_load    = 1'b0;
    w_tmr_value   = TO_LOAD;
    w_shift_stat  = 1'b0;
    w_shift_dyn   = 1'b0;
    w_commit_stat = 1'b0;
    w_commit_dyn  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          w_status_nxt = STATUS_DONE;
          w_cnt_nxt    = '0;
          case (rx_data)
            OP_LOAD_STAT: w_state_nxt = S_LOAD_STAT;
            OP_LOAD_DYN:  w_state_nxt = S_LOAD_DYN;
            OP_RUN_ALL: begin
              w_state_nxt   = S_ARM;
              w_run_all_nxt = 1'b1;
              w_tmr_load    = 1'b1;
              w_tmr_value   = GAP_LOAD;
            end
            OP_RUN_DYN: begin
              w_state_nxt   = S_ARM;
              w_run_all_nxt = 1'b0;
              w_tmr_load    = 1'b1;
              w_tmr_value   = GAP_LOAD;
            end
            default: begin
              w_state_nxt              = S_REPORT;
              w_status_nxt[ST_BAD_CMD] = 1'b1;
            end
          endcase
        end
      end
      S_LOAD_STAT: begin
        if (w_rx_fire) begin
          w_shift_stat = 1'b1;
          if (r_cnt == CW'(STAT_B - 1)) begin
            w_commit_stat = 1'b1;
            w_state_nxt   = S_REPORT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_LOAD_DYN: begin
        if (w_rx_fire) begin
          w_shift_dyn = 1'b1;
          if (r_cnt == CW'(DYN_B - 1)) begin
            w_commit_dyn = 1'b1;
            w_state_nxt  = S_REPORT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_ARM: begin
        if (w_tmr_expired) begin
          w_state_nxt = r_run_all ? S_RUN_STAT : S_RUN_DYN;
          w_tmr_load  = 1'b1;
        end
      end
      S_RUN_STAT: begin
        // Completion takes priority over a coincident timeout.
        if (end_config) begin
          w_status_nxt[ST_STAT_MIS] = xor_out_stat;
          w_state_nxt               = S_WAIT_STAT_LOW;
          w_tmr_load                = 1'b1;
        end else if (w_tmr_expired) begin
          w_status_nxt[ST_STAT_TO] = 1'b1;
          w_state_nxt              = S_REPORT;
        end
      end
      S_WAIT_STAT_LOW: begin
        if (!end_config) begin
          w_state_nxt = S_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_value = GAP_LOAD;
        end else if (w_tmr_expired) begin
          w_status_nxt[ST_STAT_TO] = 1'b1;
          w_state_nxt              = S_REPORT;
        end
      end
      S_GAP: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_RUN_DYN;
          w_tmr_load  = 1'b1;
        end
      end
      S_RUN_DYN: begin
        if (end_config) begin
          w_status_nxt[ST_DYN_MIS] = xor_out_dyn;
          w_state_nxt              = S_WAIT_DYN_LOW;
          w_tmr_load               = 1'b1;
        end else if (w_tmr_expired) begin
          w_status_nxt[ST_DYN_TO] = 1'b1;
          w_state_nxt             = S_REPORT;
        end
      end
      S_WAIT_DYN_LOW: begin
        if (!end_config) begin
          w_state_nxt = S_REPORT;
        end else if (w_tmr_expired) begin
          w_status_nxt[ST_DYN_TO] = 1'b1;
          w_state_nxt             = S_REPORT;
        end
      end
      S_REPORT: begin
        if (w_tx_fire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    w_rx_ready_nxt  = 1'b0;
    w_tx_valid_nxt  = 1'b0;
    w_start_nxt     = 1'b0;
    w_flag_stat_nxt = 1'b0;
    w_flag_dyn_nxt  = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_tx_data_nxt   = r_tx_data;
    case (w_state_nxt)
      S_IDLE, S_LOAD_STAT, S_LOAD_DYN: w_rx_ready_nxt = 1'b1;
      S_ARM, S_WAIT_STAT_LOW, S_GAP, S_WAIT_DYN_LOW: w_start_nxt = 1'b1;
      S_RUN_STAT: begin
        w_start_nxt     = 1'b1;
        w_flag_stat_nxt = 1'b1;
      end
      S_RUN_DYN: begin
        w_start_nxt    = 1'b1;
        w_flag_dyn_nxt = 1'b1;
      end
      S_REPORT: w_tx_valid_nxt = 1'b1;
      default: w_rx_ready_nxt = 1'b0;
    endcase
    // Status byte is captured once on REPORT entry and held through backpressure.
    if ((w_state_nxt == S_REPORT) && (r_state != S_REPORT)) begin
      w_tx_data_nxt = w_status_nxt;
    end
  end

  // Datapath: shadows, byte counter, status and run-mode registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow_stat <= '0;
      r_shadow_dyn  <= '0;
      r_cnt         <= '0;
      r_status      <= '0;
      r_run_all     <= 1'b0;
    end else begin
      if (w_shift_stat) r_shadow_stat <= w_stat_word;
      if (w_shift_dyn)  r_shadow_dyn  <= w_dyn_word;
      r_cnt     <= w_cnt_nxt;
      r_status  <= w_status_nxt;
      r_run_all <= w_run_all_nxt;
    end
  end

  // Output registers; config words update only on the final payload byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_ready    <= 1'b1;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_start       <= 1'b0;
      r_flag_stat   <= 1'b0;
      r_flag_dyn    <= 1'b0;
      r_busy        <= 1'b0;
      r_static_conf <= '0;
      r_dyn_conf    <= '0;
    end else begin
      r_rx_ready  <= w_rx_ready_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_start     <= w_start_nxt;
      r_flag_stat <= w_flag_stat_nxt;
      r_flag_dyn  <= w_flag_dyn_nxt;
      r_busy      <= w_busy_nxt;
      if (w_commit_stat) r_static_conf <= w_stat_word;
      if (w_commit_dyn)  r_dyn_conf    <= w_dyn_word;
    end
  end

  assign rx_ready          = r_rx_ready;
  assign tx_valid          = r_tx_valid;
  assign tx_data           = r_tx_data;
  assign start_ASIC_config = r_start;
  assign flag_stat         = r_flag_stat;
  assign flag_dyn          = r_flag_dyn;
  assign busy              = r_busy;
  assign static_conf_ear   = r_static_conf;
  assign dynamic_conf      = r_dyn_conf;

endmodule

// File: tb/tb_asic_cfg_sequencer.sv
// Directed bench for asic_cfg_sequencer: table-driven load/opcode vectors plus
// hand-written run, timeout, race, backpressure and reset sequences.
module tb_asic_cfg_sequencer;

  localparam int unsigned TO_CYC  = 100;
  localparam int unsigned GAP_CYC = 16;
  localparam logic [87:0] PAT_S   = 88'h00F123456789ABCDEF012F;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [87:0] static_conf_ear;
  logic [15:0] dynamic_conf;
  logic        start_ASIC_config;
  logic        flag_stat;
  logic        flag_dyn;
  logic        end_config = 1'b0;
  logic        xor_out_stat;
  logic        xor_out_dyn;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit br_en = 1'b0;
  int br_delay = 50;
  int br_cnt = 0;
  int n_overlap = 0;
  int n_stat_hi = 0;
  int n_dyn_hi = 0;

  typedef struct {
    logic [7:0]  op;
    int          nb;
    logic [87:0] pay;
    logic [7:0]  st;
    logic [87:0] exp_s;
    logic [15:0] exp_d;
  } vec_t;

  vec_t        tv[8];
  logic [87:0] pay;
  logic [87:0] prev_s;
  logic [15:0] prev_d;
  int          t0, t1, t2, snap;

  asic_cfg_sequencer #(
    .TIMEOUT_CYCLES (TO_CYC),
    .GAP_CYCLES     (GAP_CYC),
    .SIZESRSTAT     (88),
    .SIZESRDYN      (16)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .static_conf_ear   (static_conf_ear),
    .dynamic_conf      (dynamic_conf),
    .start_ASIC_config (start_ASIC_config),
    .flag_stat         (flag_stat),
    .flag_dyn          (flag_dyn),
    .end_config        (end_config),
    .xor_out_stat      (xor_out_stat),
    .xor_out_dyn       (xor_out_dyn),
    .busy              (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Bridge model and flag monitor: raise end_config br_delay cycles after a flag, drop it once flags clear.
  always @(negedge CLK) begin
    if (flag_stat && flag_dyn) n_overlap = n_overlap + 1;
    if (flag_stat) n_stat_hi = n_stat_hi + 1;
    if (flag_dyn)  n_dyn_hi  = n_dyn_hi + 1;
    if (!br_en) begin
      end_config = 1'b0;
      br_cnt     = 0;
    end else if (flag_stat || flag_dyn) begin
      if (!end_config) begin
        if (br_cnt == br_delay - 1) end_config = 1'b1;
        else br_cnt = br_cnt + 1;
      end
    end else begin
      end_config = 1'b0;
      br_cnt     = 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte from a negedge and return on the negedge after it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    check("rx_accept", rx_ready, 1);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  // Wait for a status byte, compare it, then complete the handshake.
  task automatic get_tx(input string name, input logic [7:0] exp);
    int k;
    k = 0;
    while (!tx_valid && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    check({name, "_tx_valid"}, tx_valid, 1);
    check({name, "_tx_data"}, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge CLK);
    tx_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_rx_ready"}, rx_ready, 1);
    check({name, "_start"}, start_ASIC_config, 0);
  endtask

  initial begin
    RST_N        = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    tx_ready     = 1'b0;
    xor_out_stat = 1'b0;
    xor_out_dyn  = 1'b0;

    tv[0] = '{8'hA5, 11, PAT_S,                       8'h01, PAT_S,                        16'h0000};
    tv[1] = '{8'h5A, 2,  88'h1234,                    8'h01, PAT_S,                        16'h1234};
    tv[2] = '{8'h77, 0,  88'h0,                       8'h81, PAT_S,                        16'h1234};
    tv[3] = '{8'hA5, 11, 88'hFFFFFFFFFFFFFFFFFFFFFF,  8'h01, 88'hFFFFFFFFFFFFFFFFFFFFFF,   16'h1234};
    tv[4] = '{8'h00, 0,  88'h0,                       8'h81, 88'hFFFFFFFFFFFFFFFFFFFFFF,   16'h1234};
    tv[5] = '{8'hFF, 0,  88'h0,                       8'h81, 88'hFFFFFFFFFFFFFFFFFFFFFF,   16'h1234};
    tv[6] = '{8'hA5, 11, PAT_S,                       8'h01, PAT_S,                        16'h1234};
    tv[7] = '{8'h5A, 2,  88'hF5AF,                    8'h01, PAT_S,                        16'hF5AF};

    repeat (3) @(negedge CLK);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_static", static_conf_ear, 0);
    check("rst_dyn", dynamic_conf, 0);
    check("rst_flags", {start_ASIC_config, flag_stat, flag_dyn, busy}, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Table: loads and bad opcodes.
    prev_s = '0;
    prev_d = '0;
    for (int i = 0; i < 8; i++) begin
      send_byte(tv[i].op);
      pay = tv[i].pay;
      for (int j = 0; j < tv[i].nb; j++) begin
        if (j == tv[i].nb - 1) begin
          check($sformatf("v%0d_partial_s", i), static_conf_ear, prev_s);
          check($sformatf("v%0d_partial_d", i), dynamic_conf, prev_d);
        end
        send_byte(pay[(tv[i].nb - 1 - j) * 8 +: 8]);
      end
      get_tx($sformatf("v%0d", i), tv[i].st);
      check($sformatf("v%0d_static", i), static_conf_ear, tv[i].exp_s);
      check($sformatf("v%0d_dyn", i), dynamic_conf, tv[i].exp_d);
      check_idle($sformatf("v%0d", i));
      prev_s = tv[i].exp_s;
      prev_d = tv[i].exp_d;
    end

    // Full run: static clean, dynamic mismatch.
    br_en        = 1'b1;
    br_delay     = 50;
    xor_out_stat = 1'b0;
    xor_out_dyn  = 1'b1;
    snap         = n_dyn_hi;
    send_byte(8'hC3);
    for (int k = 0; k < 100 && !start_ASIC_config; k++) @(negedge CLK);
    t0 = cyc;
    for (int k = 0; k < 100 && !flag_stat; k++) @(negedge CLK);
    t1 = cyc;
    check("run_gap", t1 - t0, GAP_CYC);
    get_tx("run_all", 8'h05);
    check("run_overlap", n_overlap, 0);
    check("run_dyn_seen", (n_dyn_hi > snap), 1);
    check_idle("run_all");

    // Timeout: end_config never rises.
    br_en = 1'b0;
    snap  = n_dyn_hi;
    send_byte(8'hC3);
    for (int k = 0; k < 100 && !flag_stat; k++) @(negedge CLK);
    t1 = cyc;
    for (int k = 0; k < 300 && flag_stat; k++) @(negedge CLK);
    t2 = cyc;
    check("to_flag_width", t2 - t1, TO_CYC);
    get_tx("timeout", 8'h09);
    check("to_no_dyn", n_dyn_hi, snap);
    check_idle("timeout");

    // Race: end_config arrives on the exact expiry cycle in both phases.
    br_en        = 1'b1;
    br_delay     = TO_CYC;
    xor_out_stat = 1'b1;
    xor_out_dyn  = 1'b0;
    send_byte(8'hC3);
    get_tx("race", 8'h03);
    check("race_overlap", n_overlap, 0);
    check_idle("race");

    // Dynamic only: static readback must be ignored and flag_stat stay low.
    br_delay     = 50;
    xor_out_stat = 1'b1;
    xor_out_dyn  = 1'b1;
    snap         = n_stat_hi;
    send_byte(8'h3C);
    get_tx("dyn_only", 8'h05);
    check("dyn_only_no_stat", n_stat_hi, snap);
    check_idle("dyn_only");
    br_en = 1'b0;

    // Bad opcode under backpressure with a byte offered during REPORT.
    send_byte(8'h77);
    for (int k = 0; k < 20; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      check($sformatf("bp%0d", k), {tx_valid, tx_data, rx_ready}, {1'b1, 8'h81, 1'b0});
      @(negedge CLK);
    end
    rx_valid = 1'b0;
    get_tx("bp", 8'h81);
    check_idle("bp");
    check("bp_static", static_conf_ear, PAT_S);

    // Reset in the middle of a static load.
    send_byte(8'hA5);
    for (int j = 0; j < 5; j++) send_byte(8'h11 * 8'(j + 1));
    RST_N = 1'b0;
    #1;
    check("mid_rst_static", static_conf_ear, 0);
    check("mid_rst_dyn", dynamic_conf, 0);
    check("mid_rst_ctrl", {rx_ready, tx_valid, tx_data, start_ASIC_config, flag_stat, flag_dyn, busy},
          {1'b1, 1'b0, 8'h00, 4'b0000});
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    send_byte(8'hA5);
    pay = PAT_S;
    for (int j = 0; j < 11; j++) send_byte(pay[(10 - j) * 8 +: 8]);
    get_tx("reload", 8'h01);
    check("reload_static", static_conf_ear, PAT_S);
    check("reload_dyn", dynamic_conf, 0);
    check_idle("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asic_cfg_sequencer.md
Name: asic_cfg_sequencer

Overview:
Upstream controller for ASIC_bridge_top. It receives host commands as a byte stream (valid/ready) and assembles the 88-bit static and 16-bit dynamic configuration words. It sequences start_ASIC_config, flag_stat and flag_dyn against end_config, then samples the xor readback results. Each command returns exactly one status byte on a byte-stream output.

Parameters:
TIMEOUT_CYCLES, 65535, max CLK cycles waiting on any end_config edge before aborting a phase
GAP_CYCLES, 16, CLK cycles between start_ASIC_config rising (or a phase end) and the next flag rising
SIZESRSTAT, 88, static config width (multiple of 8)
SIZESRDYN, 16, dynamic config width (multiple of 8)

Ports:
CLK  in  1  system clock (16 MHz)
RST_N  in  1  asynchronous active-low reset
rx_data  in  8  command/payload byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid&rx_ready
tx_data  out  8  status byte
tx_valid  out  1  status byte valid, held until tx_ready
tx_ready  in  1  consumer ready
static_conf_ear  out  SIZESRSTAT  static config to bridge
dynamic_conf  out  SIZESRDYN  dynamic config to bridge
start_ASIC_config  out  1  bridge arm level
flag_stat  out  1  request static configuration
flag_dyn  out  1  request dynamic configuration
end_config  in  1  bridge completion level
xor_out_stat  in  1  static readback mismatch (1 = mismatch)
xor_out_dyn  in  1  dynamic readback mismatch
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, except rx_ready=1 (state IDLE). Shadow registers are 0 and the state is IDLE.
- Opcodes:
  - 0xA5: load static. Followed by SIZESRSTAT/8 bytes, MSB first.
  - 0x5A: load dynamic. Followed by SIZESRDYN/8 bytes, MSB first.
  - 0xC3: run static then dynamic.
  - 0x3C: run dynamic only.
  - Any other value: bad command.
- Status byte bits:
  - b0: done (always 1)
  - b1: static mismatch
  - b2: dynamic mismatch
  - b3: static timeout
  - b4: dynamic timeout
  - b7: bad command
  - All other bits 0.
- States: IDLE, LOAD_STAT, LOAD_DYN, ARM, RUN_STAT, WAIT_STAT_LOW, GAP, RUN_DYN, WAIT_DYN_LOW, REPORT.
- rx_ready=1 only in IDLE, LOAD_STAT and LOAD_DYN.
- Loading:
  - Each accepted payload byte shifts into the shadow register: shadow <= {shadow[W-9:0], byte}. A byte counter tracks position.
  - On the last byte, the shadow is copied to static_conf_ear or dynamic_conf in the same edge; then go to REPORT with status 0x01.
  - Outputs never show partial words.
- Run command accepted (0xC3 or 0x3C): go to ARM.
  - start_ASIC_config=1 and stays 1 until REPORT is entered.
  - After GAP_CYCLES, raise flag_stat (RUN_STAT) or flag_dyn (RUN_DYN).
- RUN_x:
  - Flag is held high and the timeout counter runs.
  - First cycle with end_config=1: sample xor_out_x into the status bit, drop the flag on the next edge, enter WAIT_x_LOW.
- WAIT_x_LOW:
  - Wait for end_config=0, with the timeout reloaded.
  - RUN_STAT path: go to GAP (flags low for GAP_CYCLES), then RUN_DYN.
  - RUN_DYN path: go to REPORT.
- Timeout:
  - Expiry in RUN_x or WAIT_x_LOW sets timeout bit x, drops the flag and goes straight to REPORT.
  - A dynamic phase is skipped after a static timeout.
  - If end_config=1 and expiry fall in the same cycle, end_config wins.
- REPORT:
  - tx_valid=1 with tx_data stable until tx_ready; then IDLE.
  - A byte offered during REPORT is not accepted.
- Bad opcode: REPORT with status 0x81; no outputs change.
- flag_stat and flag_dyn are never high simultaneously.
- RST_N low mid-operation: immediate return to reset values, including config outputs and shadows. A partial load is discarded.

Decomposition:
- Package asic_cfg_pkg:
  - opcode localparams (OP_LOAD_STAT, OP_LOAD_DYN, OP_RUN_ALL, OP_RUN_DYN)
  - status bit indices
  - state enum typedef
  - STAT_BYTES=11, DYN_BYTES=2
- Sub-module asic_cfg_timer: loadable down-counter (load, value, expired). One instance is shared for the GAP, ARM and timeout intervals; width = $clog2(max(TIMEOUT_CYCLES,GAP_CYCLES)+1).

Test Plan:
- Static load: send A5 00 F1 23 45 67 89 AB CD EF 01 2F -> static_conf_ear=88'h00F123456789ABCDEF012F only after the last byte, tx byte 0x01, busy returns 0.
- Dynamic load and full run: send 5A F5 AF -> dynamic_conf=16'hF5AF, tx 0x01. Then send C3 with a bridge model asserting end_config 50 cycles after each flag, xor_out_stat=0 and xor_out_dyn=1 -> flag_stat rises GAP_CYCLES after start_ASIC_config, flags never overlap, tx 0x05.
- Timeout: TIMEOUT_CYCLES=100, send C3, end_config held 0 -> flag_stat drops after 100 cycles, flag_dyn never rises, tx 0x09.
- Bad opcode and backpressure: send 77 with tx_ready=0 for 20 cycles -> tx_valid=1 and tx_data=0x81 stable, rx_ready=0 throughout; handshake completes, then IDLE.
- Reset mid-load: after A5 plus 5 bytes, pulse RST_N low -> all outputs 0, rx_ready=1. A fresh A5 plus 11 bytes loads correctly from byte 0.
- Race: end_config rises on the same cycle the timeout expires -> status shows no timeout bit; xor_out_stat value is captured.
